// File: rtl/rgb_ram_writer.sv
// Raster pixel stream to block-addressed RAM writes for the column RAM bank.
// Reports frame completion, early restarts (short_frame) and trailing pixels (overflow).
module rgb_ram_writer #(
  parameter int unsigned NB_BLOCKS        = 15,
  parameter int unsigned PIXELS_PER_BLOCK = 80
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [23:0] rgb_data,
  input  logic        rgb_valid,
  input  logic        rgb_sof,
  output logic [3:0]  block_number,
  output logic [6:0]  pixel_number,
  output logic [23:0] ram_data,
  output logic        block_write_enable,
  output logic        frame_done,
  output logic        short_frame,
  output logic        overflow
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] LAST_BLK = 4'(NB_BLOCKS - 1);
  localparam logic [6:0] LAST_PIX = 7'(PIXELS_PER_BLOCK - 1);

  logic [1:0] state;
  logic [3:0] blk;
  logic [6:0] pix;

  logic       start;
  logic       accept;
  logic       last;
  logic [3:0] wblk;
  logic [6:0] wpix;

  // A valid SOF overrides the running counters in every state, so the write
  // address is selected here and the counters advance from it.
  always_comb begin
    start  = rgb_valid & rgb_sof;
    accept = start | (rgb_valid & (state == FILL));
    wblk   = start ? '0 : blk;
    wpix   = start ? '0 : pix;
    last   = (wblk == LAST_BLK) && (wpix == LAST_PIX);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state              <= IDLE;
      blk                <= '0;
      pix                <= '0;
      block_number       <= '0;
      pixel_number       <= '0;
      ram_data           <= '0;
      block_write_enable <= 1'b0;
      frame_done         <= 1'b0;
      short_frame        <= 1'b0;
      overflow           <= 1'b0;
    end else begin
      block_write_enable <= accept;
      frame_done         <= accept & last;
      short_frame        <= start & (state == FILL) & ~last;

      if (start) begin
        overflow <= 1'b0;
      end else if (rgb_valid && (state == DONE)) begin
        overflow <= 1'b1;
      end

      if (accept) begin
        block_number <= wblk;
        pixel_number <= wpix;
        ram_data     <= rgb_data;
        if (last) begin
          blk   <= '0;
          pix   <= '0;
          state <= DONE;
        end else if (wpix == LAST_PIX) begin
          blk   <= wblk + 4'd1;
          pix   <= '0;
          state <= FILL;
        end else begin
          blk   <= wblk;
          pix   <= wpix + 7'd1;
          state <= FILL;
        end
      end
    end
  end

endmodule
